// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit feeding the register file write port.
// One op in flight: 32 shift-add / restoring-divide steps, then a one-cycle write-back.
module mul_div_unit #(
  parameter int WIDTH    = 32,
  parameter int ZERO_REG = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       dest_reg,
  output logic             busy,
  output logic             done,
  output logic             write_to_reg_Flag,
  output logic [3:0]       write_reg,
  output logic [WIDTH-1:0] write_data,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]       op_r;
  logic [3:0]       dest_r;
  logic [WIDTH-1:0] m;       // multiplicand for MUL*, divisor for DIV/REM
  logic [WIDTH-1:0] hi, lo;  // product hi:lo, or remainder:quotient
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ge, div_zero;

  assign div_zero = op[1] && (operand_b == '0);
  assign busy     = (state == RUN);

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, m});
    div_diff = div_sh - {1'b0, m};
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = div_zero ? DONE : RUN;
      RUN:  if (cnt == CW'(WIDTH-1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r <= '0; dest_r <= '0; m <= '0; hi <= '0; lo <= '0; cnt <= '0;
      done <= 1'b0; write_to_reg_Flag <= 1'b0; write_reg <= '0;
      write_data <= '0; div_by_zero <= 1'b0;
    end else begin
      done              <= 1'b0;
      write_to_reg_Flag <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r   <= op;
          dest_r <= dest_reg;
          cnt    <= '0;
          m      <= op[1] ? operand_b : operand_a;
          if (div_zero) begin
            // Preload so the common result mux yields all-ones / dividend.
            div_by_zero <= 1'b1;
            hi          <= operand_a;
            lo          <= '1;
          end else begin
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= op[1] ? operand_a : operand_b;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_r[1]) begin
            hi <= div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
        end
        DONE: begin
          done              <= 1'b1;
          write_to_reg_Flag <= (dest_r != 4'(ZERO_REG));
          write_reg         <= dest_r;
          write_data        <= op_r[0] ? hi : lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, mid-op reset and
// randomized ops checked against a plain-arithmetic reference model.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic [3:0]  dest_reg;
  logic        busy, done, write_to_reg_Flag, div_by_zero;
  logic [3:0]  write_reg;
  logic [31:0] write_data;

  int vectors = 0;
  int miscompares = 0;

  mul_div_unit #(.WIDTH(32), .ZERO_REG(14)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .busy(busy), .done(done), .write_to_reg_Flag(write_to_reg_Flag),
    .write_reg(write_reg), .write_data(write_data), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one op, follow it to its done pulse and check timing and results.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] d, input bit poke);
    int k, busy_n, flag_n;
    bit dz;
    logic [31:0] exp;
    exp = model(o, a, b);
    dz  = o[1] && (b == 0);
    op = o; operand_a = a; operand_b = b; dest_reg = d; start = 1'b1;
    step();
    start = 1'b0;
    op = 2'($urandom); operand_a = $urandom; operand_b = $urandom; dest_reg = 4'($urandom);
    k = 0; busy_n = 0; flag_n = 0;
    while (done !== 1'b1 && k < 60) begin
      busy_n += int'(busy);
      flag_n += int'(write_to_reg_Flag);
      start = (poke && k == 5);
      step();
      k++;
    end
    start = 1'b0;
    chk("latency", 64'(k), dz ? 64'd1 : 64'd33);
    chk("write_data", 64'(write_data), 64'(exp));
    chk("write_reg", 64'(write_reg), 64'(d));
    chk("wr_flag", 64'(write_to_reg_Flag), 64'(d != 4'd14));
    chk("div_by_zero", 64'(div_by_zero), 64'(dz));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("busy_cycles", 64'(busy_n), dz ? 64'd0 : 64'd32);
    chk("early_flag", 64'(flag_n), 64'd0);
    step();
    chk("done_pulse", 64'(done), 64'd0);
    chk("flag_pulse", 64'(write_to_reg_Flag), 64'd0);
    chk("data_hold", 64'(write_data), 64'(exp));
    chk("dbz_hold", 64'(div_by_zero), 64'(dz));
  endtask

  initial begin
    int extra;
    rst = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest_reg = '0;
    step(); step();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_flag", 64'(write_to_reg_Flag), 0);
    chk("rst_wreg", 64'(write_reg), 0);
    chk("rst_wdata", 64'(write_data), 0);
    chk("rst_dbz", 64'(div_by_zero), 0);
    rst = 1'b1;
    step();

    run_op(2'd0, 32'h0001_0003, 32'h0000_0005, 4'd3, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 4'd1, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 4'd2, 1'b0);
    run_op(2'd2, 32'h1234, 32'd0, 4'd7, 1'b0);
    run_op(2'd3, 32'h1234, 32'd0, 4'd8, 1'b0);
    run_op(2'd0, 32'hDEAD_BEEF, 32'h0000_1001, 4'd14, 1'b1);

    // Abort a MUL mid-run; nothing of it may ever be written back.
    op = 2'd0; operand_a = 32'h55; operand_b = 32'h77; dest_reg = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_busy", 64'(busy), 0);
    chk("mid_done", 64'(done), 0);
    chk("mid_flag", 64'(write_to_reg_Flag), 0);
    chk("mid_wreg", 64'(write_reg), 0);
    chk("mid_wdata", 64'(write_data), 0);
    chk("mid_dbz", 64'(div_by_zero), 0);
    extra = 0;
    repeat (40) begin
      extra += int'(done) + int'(write_to_reg_Flag) + int'(busy);
      step();
    end
    chk("mid_no_wb", 64'(extra), 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_op(2'($urandom), a, b, 4'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
